dwt_pass_sequencer: RTL and testbench

DWT_PASS_SEQUENCER -- requirements
Module: dwt_pass_sequencer

---
 rtl/dwt_pass_sequencer.sv | 135 +++++++++++++
 tb/tb_dwt_pass_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dwt_pass_sequencer.sv
// Sequences the passes of a multi-level 2-D DWT: one pass per level, halving the region
// each time, stopping at the requested level or when the region gets too small.
module dwt_pass_sequencer #(
    parameter logic [10:0] IMG_WIDTH  = 11'd1024,
    parameter logic [10:0] IMG_HEIGHT = 11'd768,
    parameter logic [3:0]  MAX_LEVEL  = 4'd10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  level,
    input  logic        level_update,
    input  logic        pass_done,
    output logic        pass_start,
    output logic [3:0]  pass_index,
    output logic [10:0] pass_width,
    output logic [10:0] pass_height,
    output logic        busy,
    output logic        all_done
);

    typedef enum logic [2:0] {StIdle, StStart, StWait, StNext, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  target_q, target_d;
    logic        pending_q, pending_d;
    logic [3:0]  pending_level_q, pending_level_d;
    logic [3:0]  pass_index_q, pass_index_d;
    logic [10:0] pass_width_q, pass_width_d;
    logic [10:0] pass_height_q, pass_height_d;
    logic        pass_start_q, pass_start_d;
    logic        busy_q, busy_d;
    logic        all_done_q, all_done_d;

    logic [3:0]  level_clamped;
    logic        load_seq;
    logic [3:0]  load_level;

    always_comb begin
        state_d         = state_q;
        target_d        = target_q;
        pending_d       = pending_q;
        pending_level_d = pending_level_q;
        pass_index_d    = pass_index_q;
        pass_width_d    = pass_width_q;
        pass_height_d   = pass_height_q;
        load_seq        = 1'b0;
        level_clamped   = (level > MAX_LEVEL) ? MAX_LEVEL : level;
        load_level      = level_clamped;

        // Updates arriving mid-sequence are parked; the newest one wins.
        if (level_update && (state_q inside {StStart, StWait, StNext})) begin
            pending_d       = 1'b1;
            pending_level_d = level_clamped;
        end

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (level_update) begin
                    load_seq   = 1'b1;
                    load_level = level_clamped;
                end
            end
            StStart: state_d = StWait;
            StWait: begin
                if (pass_done) begin
                    if (pending_d) begin
                        pending_d  = 1'b0;
                        load_seq   = 1'b1;
                        load_level = pending_level_d;
                    end else if ((pass_index_q + 4'd1 == target_q) ||
                                 ((pass_width_q >> 1) < 11'd2) ||
                                 ((pass_height_q >> 1) < 11'd2)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StNext;
                    end
                end
            end
            StNext: begin
                pass_index_d  = pass_index_q + 4'd1;
                pass_width_d  = pass_width_q >> 1;
                pass_height_d = pass_height_q >> 1;
                state_d       = StStart;
            end
            default: state_d = StIdle;
        endcase

        if (load_seq) begin
            target_d      = load_level;
            pass_index_d  = 4'd0;
            pass_width_d  = IMG_WIDTH;
            pass_height_d = IMG_HEIGHT;
            state_d       = (load_level != 4'd0) ? StStart : StDone;
        end

        pass_start_d = (state_d == StStart);
        busy_d       = (state_d inside {StStart, StWait, StNext});
        all_done_d   = (state_d == StDone);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= StIdle;
            target_q        <= 4'd0;
            pending_q       <= 1'b0;
            pending_level_q <= 4'd0;
            pass_index_q    <= 4'd0;
            pass_width_q    <= IMG_WIDTH;
            pass_height_q   <= IMG_HEIGHT;
            pass_start_q    <= 1'b0;
            busy_q          <= 1'b0;
            all_done_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            pending_q       <= pending_d;
            pending_level_q <= pending_level_d;
            pass_index_q    <= pass_index_d;
            pass_width_q    <= pass_width_d;
            pass_height_q   <= pass_height_d;
            pass_start_q    <= pass_start_d;
            busy_q          <= busy_d;
            all_done_q      <= all_done_d;
        end
    end

    assign pass_start  = pass_start_q;
    assign pass_index  = pass_index_q;
    assign pass_width  = pass_width_q;
    assign pass_height = pass_height_q;
    assign busy        = busy_q;
    assign all_done    = all_done_q;

endmodule

// File: tb/tb_dwt_pass_sequencer.sv
// Directed bench for dwt_pass_sequencer: drives on the falling edge, checks on the falling edge.
module tb_dwt_pass_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  level = 4'd0;
    logic        level_update = 1'b0;
    logic        pass_done = 1'b0;
    logic        pass_start;
    logic [3:0]  pass_index;
    logic [10:0] pass_width;
    logic [10:0] pass_height;
    logic        busy;
    logic        all_done;

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;
    int n_done   = 0;
    int s0, d0;

    dwt_pass_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .level       (level),
        .level_update(level_update),
        .pass_done   (pass_done),
        .pass_start  (pass_start),
        .pass_index  (pass_index),
        .pass_width  (pass_width),
        .pass_height (pass_height),
        .busy        (busy),
        .all_done    (all_done)
    );

    always #5 clock = ~clock;

    // Pulses seen in the previous cycle are counted at the rising edge, before flops update.
    always @(posedge clock) begin
        if (pass_start) n_start <= n_start + 1;
        if (all_done)   n_done  <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_level(input logic [3:0] l);
        level        = l;
        level_update = 1'b1;
        tick(1);
        level_update = 1'b0;
    endtask

    task automatic pulse_done();
        pass_done = 1'b1;
        tick(1);
        pass_done = 1'b0;
    endtask

    task automatic wait_start(input int i);
        bit found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (pass_start) found = 1'b1;
            else tick(1);
        end
        check($sformatf("start_seen[%0d]", i), {31'd0, found}, 32'd1);
        check($sformatf("index[%0d]", i), {28'd0, pass_index}, i);
        check($sformatf("width[%0d]", i), {21'd0, pass_width}, 32'd1024 >> i);
        check($sformatf("height[%0d]", i), {21'd0, pass_height}, 32'd768 >> i);
    endtask

    // One pass with pass_done 5 cycles after pass_start.
    task automatic do_pass(input int i, input bit last);
        wait_start(i);
        tick(4);
        pulse_done();
        check($sformatf("all_done_after[%0d]", i), {31'd0, all_done}, {31'd0, last});
        check($sformatf("busy_after[%0d]", i), {31'd0, busy}, {31'd0, !last});
    endtask

    task automatic run_level(input logic [3:0] l, input int passes);
        send_level(l);
        for (int i = 0; i < passes; i++) do_pass(i, i == passes - 1);
        tick(1);
        check("all_done_one_cycle", {31'd0, all_done}, 32'd0);
        check("pass_start_idle", {31'd0, pass_start}, 32'd0);
    endtask

    initial begin
        tick(3);
        check("rst_pass_start", {31'd0, pass_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_all_done", {31'd0, all_done}, 32'd0);
        check("rst_index", {28'd0, pass_index}, 32'd0);
        check("rst_width", {21'd0, pass_width}, 32'd1024);
        check("rst_height", {21'd0, pass_height}, 32'd768);
        reset = 1'b0;
        tick(2);

        // Level 3: three passes.
        tick(1); s0 = n_start; d0 = n_done;
        run_level(4'd3, 3);
        tick(1);
        check("l3_starts", n_start - s0, 32'd3);
        check("l3_dones", n_done - d0, 32'd1);

        // Levels 10 and 15: height runs out after nine passes.
        run_level(4'd10, 9);
        run_level(4'd15, 9);

        // Level 0: immediate all_done, no pass.
        tick(1); s0 = n_start;
        send_level(4'd0);
        check("l0_all_done", {31'd0, all_done}, 32'd1);
        check("l0_busy", {31'd0, busy}, 32'd0);
        check("l0_pass_start", {31'd0, pass_start}, 32'd0);
        tick(2);
        check("l0_all_done_gone", {31'd0, all_done}, 32'd0);
        check("l0_starts", n_start - s0, 32'd0);

        // Level 4 redirected to level 2 during pass 1.
        tick(1); d0 = n_done;
        send_level(4'd4);
        do_pass(0, 1'b0);
        wait_start(1);
        tick(2);
        send_level(4'd2);
        tick(1);
        pulse_done();
        check("redir_no_all_done", {31'd0, all_done}, 32'd0);
        do_pass(0, 1'b0);
        do_pass(1, 1'b1);
        tick(2);
        check("redir_dones", n_done - d0, 32'd1);

        // Update and pass_done in the same WAIT cycle.
        send_level(4'd3);
        tick(3);
        level = 4'd1; level_update = 1'b1; pass_done = 1'b1;
        tick(1);
        level_update = 1'b0; pass_done = 1'b0;
        check("same_cycle_restart", {31'd0, pass_start}, 32'd1);
        do_pass(0, 1'b1);
        tick(1);

        // Reset in WAIT of pass 2, then a stray pass_done.
        send_level(4'd4);
        do_pass(0, 1'b0);
        do_pass(1, 1'b0);
        wait_start(2);
        tick(2);
        level = 4'd5; level_update = 1'b1; reset = 1'b1;
        tick(1);
        level_update = 1'b0; reset = 1'b0;
        s0 = n_start; d0 = n_done;
        pulse_done();
        tick(5);
        check("rr_starts", n_start - s0, 32'd0);
        check("rr_dones", n_done - d0, 32'd0);
        check("rr_busy", {31'd0, busy}, 32'd0);
        check("rr_index", {28'd0, pass_index}, 32'd0);
        check("rr_width", {21'd0, pass_width}, 32'd1024);
        check("rr_height", {21'd0, pass_height}, 32'd768);

        // Stray pass_done in IDLE, then in the START cycle.
        s0 = n_start; d0 = n_done;
        pulse_done();
        tick(2);
        check("idle_stray_starts", n_start - s0, 32'd0);
        check("idle_stray_dones", n_done - d0, 32'd0);
        check("idle_stray_busy", {31'd0, busy}, 32'd0);
        send_level(4'd2);
        check("start_cycle", {31'd0, pass_start}, 32'd1);
        pulse_done();
        check("start_stray_busy", {31'd0, busy}, 32'd1);
        check("start_stray_pass_start", {31'd0, pass_start}, 32'd0);
        check("start_stray_index", {28'd0, pass_index}, 32'd0);
        tick(3);
        pulse_done();
        check("start_stray_not_done", {31'd0, all_done}, 32'd0);
        do_pass(1, 1'b1);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
